sync_fifo_ctrl: RTL
===================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 3, meaning the memory address width (depth 2^AW = 8).
REQ-002 The block SHALL have parameter DW, default 4, meaning the data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all state; mem_clkr and mem_clkw are both driven from it.
REQ-004 The block SHALL have port rstn, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port wr_valid, input, 1, meaning the upstream offers a word.
REQ-006 The block SHALL have port wr_data, input, DW, meaning the upstream word.
REQ-007 The block SHALL have port wr_ready, output, 1, meaning a word can be accepted; it equals !full.
REQ-008 The block SHALL have port rd_valid, output, 1, meaning rd_data holds a valid word.
REQ-009 The block SHALL have port rd_data, output, DW, meaning the downstream word; it equals mem_qr.
REQ-010 The block SHALL have port rd_ready, input, 1, meaning the downstream accepts rd_data.
REQ-011 The block SHALL have port flush, input, 1, a synchronous clear of all contents.
REQ-012 The block SHALL have port level, output, AW+1, meaning the total words held (RAM plus output slot), 0..2^AW+1.
REQ-013 The block SHALL have port overflow, output, 1, a sticky flag set by a write attempt while full.
REQ-014 The block SHALL have ports mem_clkw, mem_clkr, mem_cew, mem_aw[AW], mem_dw[DW], mem_cer, mem_ar[AW], mem_rstnr, all outputs, driving the simple-dual-port memory.
REQ-015 The block SHALL have port mem_qr, input, DW, the memory read data, valid 1 cycle after mem_cer and held while mem_cer is low.

Function
REQ-016 The block SHALL maintain registers wptr[AW], rptr[AW], mcount[AW+1] (words in RAM, 0..2^AW), and rd_valid.
REQ-017 The block SHALL drive full = (mcount == 2^AW).
REQ-018 A write SHALL occur when wr_valid && !full; in that cycle mem_cew=1, mem_aw=wptr, mem_dw=wr_data (combinational), and wptr SHALL increment modulo 2^AW.
REQ-019 The block SHALL drive rd_issue = (mcount != 0) && (!rd_valid || rd_ready) && !flush; mem_cer = rd_issue and mem_ar = rptr, and rptr SHALL increment modulo 2^AW on rd_issue.
REQ-020 rd_valid SHALL be set the cycle after rd_issue, and SHALL be cleared the cycle after rd_valid && rd_ready with no rd_issue.
REQ-021 Back-to-back consumption with rd_ready held high and mcount>0 SHALL sustain one word per cycle.
REQ-022 mcount SHALL become mcount + write - rd_issue; a simultaneous write and read leaves it unchanged.
REQ-023 Reads SHALL never be issued when mcount==0, even when a write occurs in the same cycle, so no read-during-write to the same address occurs; written data is readable on the following cycle.
REQ-024 level SHALL equal mcount + rd_valid and be registered-consistent with both.
REQ-025 When wr_valid && full, the word SHALL be dropped, no pointer SHALL change, and overflow SHALL be set to 1.
REQ-026 When flush=1, wptr, rptr, mcount and rd_valid SHALL be cleared on the next edge, a same-cycle write SHALL be discarded (mem_cew=0), and overflow SHALL be retained.
REQ-027 Wrap-around SHALL be seamless: word order SHALL be preserved across pointer wrap from 2^AW-1 to 0.
REQ-028 mem_rstnr SHALL be driven equal to rstn.

Reset
REQ-029 While rstn=0 at a clock edge, the block SHALL set wptr=0, rptr=0, mcount=0, rd_valid=0, overflow=0, which gives level=0, wr_ready=1, mem_cew=0, and mem_cer=0.
REQ-030 Reset asserted mid-transfer SHALL discard all contents; the first word written after release SHALL be the first word read.

Verification
REQ-031 Bench SHALL cover: after reset, write 1,2,3 on consecutive cycles with rd_ready=0 -> rd_valid rises 2 cycles after first write, rd_data=1, level=3.
REQ-032 Bench SHALL cover: 9 writes 0..8 with rd_ready=0 -> wr_ready=0 after the 9th (level=9), a 10th write sets overflow=1 and is dropped, reads then return 0..8 in order.
REQ-033 Bench SHALL cover: continuous write and read with rd_ready=1 for 20 words -> one word per cycle out, values in order across two pointer wraps, level stays at most 2.
REQ-034 Bench SHALL cover: flush with level=5 and simultaneous wr_valid -> next cycle level=0, rd_valid=0, and no stale data is output afterwards.
REQ-035 Bench SHALL cover: rd_ready toggling 1/0 randomly with random wr_valid for 1000 cycles -> output sequence equals input sequence (scoreboard), rd_data stable while rd_valid && !rd_ready.
REQ-036 Bench SHALL cover: rstn=0 asserted with level=4 -> next cycle level=0, overflow=0; a subsequent write of value A is read first.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller in front of a simple-dual-port RAM with a registered read
// stage. The RAM read port output doubles as the single output slot.
module sync_fifo_ctrl #(
   parameter int AW = 3,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   input  logic          rd_ready,
   input  logic          flush,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic          mem_clkw,
   output logic          mem_clkr,
   output logic          mem_cew,
   output logic [AW-1:0] mem_aw,
   output logic [DW-1:0] mem_dw,
   output logic          mem_cer,
   output logic [AW-1:0] mem_ar,
   output logic          mem_rstnr,
   input  logic [DW-1:0] mem_qr
);

   localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_mcount;
   logic          r_rd_valid;
   logic          r_overflow;

   logic          w_full;
   logic          w_wr;
   logic          w_issue;
   logic [AW:0]   w_mcount_nxt;
   logic          w_rd_valid_nxt;

   assign w_full  = (r_mcount == DEPTH);
   assign w_wr    = wr_valid && !w_full && !flush;
   // An empty RAM never issues a read, so a same-cycle write is never read back early.
   assign w_issue = (r_mcount != {(AW+1){1'b0}}) && (!r_rd_valid || rd_ready) && !flush;

   // Next-state values for the RAM word count and the output-slot valid flag.
   always_comb begin
      w_mcount_nxt   = r_mcount;
      w_rd_valid_nxt = r_rd_valid;
      case ({w_wr, w_issue})
         2'b10:   w_mcount_nxt = r_mcount + CNT_ONE;
         2'b01:   w_mcount_nxt = r_mcount - CNT_ONE;
         default: w_mcount_nxt = r_mcount;
      endcase
      if (w_issue) begin
         w_rd_valid_nxt = 1'b1;
      end else if (r_rd_valid && rd_ready) begin
         w_rd_valid_nxt = 1'b0;
      end else begin
         w_rd_valid_nxt = r_rd_valid;
      end
   end

   // Pointer, count, valid and sticky overflow state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr     <= {AW{1'b0}};
         r_rptr     <= {AW{1'b0}};
         r_mcount   <= {(AW+1){1'b0}};
         r_rd_valid <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
         end
         if (flush) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_mcount   <= {(AW+1){1'b0}};
            r_rd_valid <= 1'b0;
         end else begin
            if (w_wr) begin
               r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_issue) begin
               r_rptr <= r_rptr + PTR_ONE;
            end
            r_mcount   <= w_mcount_nxt;
            r_rd_valid <= w_rd_valid_nxt;
         end
      end
   end

   assign wr_ready  = !w_full;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = mem_qr;
   assign level     = r_mcount + {{AW{1'b0}}, r_rd_valid};
   assign overflow  = r_overflow;
   assign mem_clkw  = clk;
   assign mem_clkr  = clk;
   assign mem_cew   = w_wr;
   assign mem_aw    = r_wptr;
   assign mem_dw    = wr_data;
   assign mem_cer   = w_issue;
   assign mem_ar    = r_rptr;
   assign mem_rstnr = rstn;

endmodule
